// File: rtl/divider_pkg.sv
// divider_pkg: shared definitions for the iterative DIV/DIVU unit.
//   DW       - datapath width (only 32 is supported)
//   state_t  - divider FSM encoding
//   cond_neg - two's complement negate when a condition bit is set
package divider_pkg;

   localparam int DW = 32;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ZERO = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // Used both for taking magnitudes on entry and for sign correction on exit.
   function automatic logic [DW-1:0] cond_neg(input logic [DW-1:0] v, input logic neg);
      return neg ? -v : v;
   endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step.
//   rem_in  - partial remainder from the previous step (DW+1 bits)
//   dvsr    - divisor magnitude
//   din     - next dividend bit shifted in
//   rem_out - partial remainder after the step
//   qbit    - quotient bit produced by this step
module div_step
   import divider_pkg::*;
(
   input  logic [DW:0]   rem_in,
   input  logic [DW-1:0] dvsr,
   input  logic          din,
   output logic [DW:0]   rem_out,
   output logic          qbit
);

   logic [DW:0] shifted;
   logic [DW:0] diff;

   always_comb begin
      shifted = {rem_in[DW-1:0], din};
      diff    = shifted - {1'b0, dvsr};
      // rem_in[DW] would be the bit shifted out; if it were set the shifted
      // value is certainly >= divisor. The remainder stays below the divisor,
      // so this never happens, but it keeps the step correct in isolation.
      qbit    = rem_in[DW] | ~diff[DW];
      rem_out = qbit ? diff : shifted;
   end

endmodule

// File: rtl/divider.sv
// divider: iterative 32-bit DIV/DIVU for the execute stage.
//   clock, reset (async, active low)
//   start, signed_op, dividend, divisor - request, sampled in IDLE
//   cancel - pipeline flush, aborts any operation in progress
//   busy   - stall request, high whenever not IDLE
//   ready  - one-cycle pulse, hi (remainder) / lo (quotient) valid
module divider
   import divider_pkg::*;
#(
   parameter int WIDTH = DW
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             signed_op,
   input  logic             cancel,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             ready,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt;
   logic [WIDTH:0]   rem;
   logic [WIDTH-1:0] quo;     // dividend bits shift out the top, quotient bits in the bottom
   logic [WIDTH-1:0] dvsr;
   logic             neg_q;   // operand signs differ (signed only)
   logic             neg_r;   // dividend negative (signed only)

   logic [WIDTH:0]   step_rem;
   logic             step_q;

   div_step u_step (
      .rem_in  (rem),
      .dvsr    (dvsr),
      .din     (quo[WIDTH-1]),
      .rem_out (step_rem),
      .qbit    (step_q)
   );

   assign busy = (state != S_IDLE);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (start && !cancel)
                    state_nxt = (divisor == '0) ? S_ZERO : S_RUN;
         S_RUN:  if (cancel)          state_nxt = S_IDLE;
                 else if (cnt == LAST) state_nxt = S_DONE;
         S_DONE: state_nxt = S_IDLE;
         S_ZERO: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt   <= '0;
         rem   <= '0;
         quo   <= '0;
         dvsr  <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         hi    <= '0;
         lo    <= '0;
         ready <= 1'b0;
      end else begin
         ready <= 1'b0;
         case (state)
            S_IDLE: if (start && !cancel) begin
               neg_q <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
               neg_r <= signed_op & dividend[WIDTH-1];
               quo   <= cond_neg(dividend, signed_op & dividend[WIDTH-1]);
               dvsr  <= cond_neg(divisor,  signed_op & divisor[WIDTH-1]);
               rem   <= '0;
               cnt   <= '0;
            end
            S_RUN: if (!cancel) begin
               rem <= step_rem;
               quo <= {quo[WIDTH-2:0], step_q};
               cnt <= cnt + CW'(1);
            end
            S_DONE: if (!cancel) begin
               // 0x80000000 / -1 wraps back to 0x80000000 here, no trap.
               lo    <= cond_neg(quo, neg_q);
               hi    <= cond_neg(rem[WIDTH-1:0], neg_r);
               ready <= 1'b1;
            end
            S_ZERO: if (!cancel) begin
               hi    <= '0;
               lo    <= '0;
               ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_divider.sv
module tb_divider;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        signed_op = 1'b0;
   logic        cancel = 1'b0;
   logic [31:0] dividend = '0;
   logic [31:0] divisor = '0;
   logic        busy, ready;
   logic [31:0] hi, lo;

   int n_chk  = 0;
   int n_pass = 0;

   divider #(.WIDTH(32)) dut (
      .clock(clock), .reset(reset), .start(start), .signed_op(signed_op),
      .cancel(cancel), .dividend(dividend), .divisor(divisor),
      .busy(busy), .ready(ready), .hi(hi), .lo(lo)
   );

   always #5 clock = ~clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        sop;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] eh;
      logic [31:0] el;
      int          elat;
   } vec_t;

   vec_t tv[9];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
   endtask

   // Reference: plain arithmetic, 64-bit for signed to avoid host overflow.
   function automatic void model(input logic sop, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] eh, output logic [31:0] el);
      longint sa, sb, q, r;
      if (b == 0) begin
         eh = '0; el = '0;
      end else if (sop) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q  = sa / sb;
         r  = sa % sb;
         el = q[31:0];
         eh = r[31:0];
      end else begin
         el = a / b;
         eh = a % b;
      end
   endfunction

   // Issues one request (now=1: drive in the current cycle), waits for ready.
   // lat = edges after the sampling edge until ready; bcyc = cycles busy seen.
   task automatic run_op(input bit now, input logic sop, input logic [31:0] a,
                         input logic [31:0] b, output int lat, output int bcyc);
      if (!now) @(negedge clock);
      start = 1'b1; signed_op = sop; dividend = a; divisor = b;
      @(negedge clock);
      start = 1'b0;
      lat = 0; bcyc = 0;
      while (!ready && lat < 200) begin
         if (busy) bcyc++;
         @(negedge clock);
         lat++;
      end
      chk("ready_seen", {31'b0, ready}, 32'd1);
   endtask

   initial begin
      int lat, bcyc, k, rcnt, bcnt;
      logic [31:0] eh, el, a, b;
      logic sop;

      tv[0] = '{1'b0, 32'd100,        32'd7,          32'h00000002, 32'h0000000E, 33};
      tv[1] = '{1'b1, 32'hFFFFFFF9,   32'h00000002,   32'hFFFFFFFF, 32'hFFFFFFFD, 33};
      tv[2] = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h00000000, 32'h80000000, 33};
      tv[3] = '{1'b0, 32'hFFFFFFFF,   32'h00000010,   32'h0000000F, 32'h0FFFFFFF, 33};
      tv[4] = '{1'b1, 32'h12345678,   32'h00000000,   32'h00000000, 32'h00000000, 1};
      tv[5] = '{1'b0, 32'hFFFFFFFF,   32'h00000001,   32'h00000000, 32'hFFFFFFFF, 33};
      tv[6] = '{1'b0, 32'h12345678,   32'h00000000,   32'h00000000, 32'h00000000, 1};
      tv[7] = '{1'b1, 32'h00000007,   32'hFFFFFFFE,   32'h00000001, 32'hFFFFFFFD, 33};
      tv[8] = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'hFFFFFFFE, 32'h0000000E, 33};

      // Reset state
      repeat (2) @(negedge clock);
      chk("rst_busy",  {31'b0, busy},  32'd0);
      chk("rst_ready", {31'b0, ready}, 32'd0);
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      reset = 1'b1;

      // Directed table
      foreach (tv[i]) begin
         run_op(1'b0, tv[i].sop, tv[i].a, tv[i].b, lat, bcyc);
         chk($sformatf("v%0d_hi", i), hi, tv[i].eh);
         chk($sformatf("v%0d_lo", i), lo, tv[i].el);
         chk($sformatf("v%0d_lat", i), lat, tv[i].elat);
         chk($sformatf("v%0d_busy_cycles", i), bcyc, tv[i].elat);
         chk($sformatf("v%0d_busy_at_ready", i), {31'b0, busy}, 32'd0);
         @(negedge clock);
         chk($sformatf("v%0d_ready_pulse", i), {31'b0, ready}, 32'd0);
         chk($sformatf("v%0d_hi_hold", i), hi, tv[i].eh);
      end

      // Back-to-back: second start in the ready cycle
      run_op(1'b0, 1'b0, 32'd100, 32'd7, lat, bcyc);
      run_op(1'b1, 1'b1, 32'hFFFFFFF9, 32'd2, lat, bcyc);
      chk("b2b_lat", lat, 33);
      chk("b2b_hi", hi, 32'hFFFFFFFF);
      chk("b2b_lo", lo, 32'hFFFFFFFD);

      // start pulse while busy is ignored
      @(negedge clock);
      start = 1'b1; signed_op = 1'b0; dividend = 32'd1000; divisor = 32'd3;
      @(negedge clock);
      start = 1'b0;
      repeat (3) @(negedge clock);
      start = 1'b1; signed_op = 1'b1; dividend = 32'd50; divisor = 32'd0;
      @(negedge clock);
      start = 1'b0;
      k = 4;
      while (!ready && k < 200) begin @(negedge clock); k++; end
      chk("ign_lat", k, 33);
      chk("ign_hi", hi, 32'd1);
      chk("ign_lo", lo, 32'd333);

      // cancel mid-run
      @(negedge clock);
      start = 1'b1; signed_op = 1'b0; dividend = 32'd100; divisor = 32'd7;
      @(negedge clock);
      start = 1'b0;
      repeat (10) @(negedge clock);
      cancel = 1'b1;
      @(negedge clock);
      cancel = 1'b0;
      chk("cancel_busy", {31'b0, busy}, 32'd0);
      rcnt = 0;
      repeat (40) begin @(negedge clock); if (ready) rcnt++; end
      chk("cancel_no_ready", rcnt, 0);
      chk("cancel_hi_hold", hi, 32'd1);
      chk("cancel_lo_hold", lo, 32'd333);
      run_op(1'b0, 1'b0, 32'd100, 32'd7, lat, bcyc);
      chk("post_cancel_hi", hi, 32'd2);
      chk("post_cancel_lo", lo, 32'd14);
      chk("post_cancel_lat", lat, 33);

      // asynchronous reset mid-run
      @(negedge clock);
      start = 1'b1; signed_op = 1'b0; dividend = 32'hFFFFFFFF; divisor = 32'h10;
      @(negedge clock);
      start = 1'b0;
      repeat (14) @(negedge clock);
      reset = 1'b0;
      #1;
      chk("arst_hi", hi, 32'd0);
      chk("arst_lo", lo, 32'd0);
      chk("arst_ready", {31'b0, ready}, 32'd0);
      chk("arst_busy", {31'b0, busy}, 32'd0);
      @(negedge clock);
      reset = 1'b1;
      rcnt = 0; bcnt = 0;
      repeat (40) begin @(negedge clock); if (ready) rcnt++; if (busy) bcnt++; end
      chk("arst_no_ready", rcnt, 0);
      chk("arst_no_busy", bcnt, 0);
      chk("arst_hi_after", hi, 32'd0);
      chk("arst_lo_after", lo, 32'd0);

      // Randomized against the reference model
      for (int i = 0; i < 150; i++) begin
         sop = 1'($urandom_range(0, 1));
         a   = $urandom;
         case ($urandom_range(0, 7))
            0:       b = 32'd0;
            1, 2:    b = 32'($urandom_range(1, 255));
            3:       b = -32'($urandom_range(1, 255));
            4:       b = 32'hFFFFFFFF;
            default: b = $urandom;
         endcase
         if ($urandom_range(0, 9) == 0) a = 32'h80000000;
         model(sop, a, b, eh, el);
         run_op(1'b0, sop, a, b, lat, bcyc);
         chk($sformatf("rnd%0d_hi(op=%0d a=%08h b=%08h)", i, sop, a, b), hi, eh);
         chk($sformatf("rnd%0d_lo(op=%0d a=%08h b=%08h)", i, sop, a, b), lo, el);
         chk($sformatf("rnd%0d_lat", i), lat, (b == 0) ? 1 : 33);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
